mig7_ui_arbiter: RTL

- Shares the single MIG7 user interface (app_*) between two requesters, port 0 and port 1, on the ui_clk domain.
- Arbitrates round-robin and issues one BL8 command at a time, with its write-data beat for writes.
- Returns read data to the requester that issued the read, using an in-order tag FIFO.
- Sits between client logic (for example a DAC playback buffer and a GT upstream packetiser) and the mig7series instance, replacing mig7_stub.

---
 rtl/mig7_arb_pkg.sv | 15 +
 rtl/mig7_arb_tag_fifo.sv | 51 +++++
 rtl/mig7_ui_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mig7_arb_pkg.sv
// Shared constants and types for the two-port MIG7 user-interface arbiter.
package mig7_arb_pkg;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  typedef enum logic [0:0] {IDLE, ISSUE} arb_state_t;

  typedef logic [0:0] port_id_t;

  function automatic logic [1:0] port_onehot(port_id_t p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mig7_arb_tag_fifo.sv
// In-order FIFO of requester IDs for outstanding reads; DEPTH must be a power of 2.
module mig7_arb_tag_fifo
  import mig7_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  port_id_t                 push_data_i,
  input  logic                     pop_i,
  output port_id_t                 head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  port_id_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so push-while-full is fine when popping.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mig7_ui_arbiter.sv
// Round-robin arbiter sharing one MIG7 app_* interface between two requesters.
// Optional statistics outputs are enabled with `define MIG7_ARB_STATS_EN.
module mig7_ui_arbiter
  import mig7_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned MASK_W    = 16,
  parameter int unsigned TAG_DEPTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  req_valid_i,
  output logic [1:0]                  req_ready_o,
  input  logic [1:0]                  req_write_i,
  input  logic [1:0][ADDR_W-1:0]      req_addr_i,
  input  logic [1:0][DATA_W-1:0]      req_wdata_i,
  input  logic [1:0][MASK_W-1:0]      req_wmask_i,
  output logic [1:0]                  rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_data_o,
  output logic [ADDR_W-1:0]           app_addr_o,
  output logic [2:0]                  app_cmd_o,
  output logic                        app_en_o,
  output logic [DATA_W-1:0]           app_wdf_data_o,
  output logic                        app_wdf_end_o,
  output logic [MASK_W-1:0]           app_wdf_mask_o,
  output logic                        app_wdf_wren_o,
  input  logic [DATA_W-1:0]           app_rd_data_i,
  input  logic                        app_rd_data_valid_i,
  input  logic                        app_rdy_i,
  input  logic                        app_wdf_rdy_i,
  output logic                        app_sr_req_o,
  output logic                        app_ref_req_o,
  output logic                        app_zq_req_o,
  input  logic                        init_calib_complete_i,
  output logic                        rd_orphan_o
`ifdef MIG7_ARB_STATS_EN
  ,
  output logic [1:0][31:0]            stat_grants_o,
  output logic [$clog2(TAG_DEPTH):0]  stat_max_outstanding_o
`endif
);

  arb_state_t                  state_q;
  port_id_t                    rr_q, gnt_q;
  logic                        app_en_q, wren_q;
  logic [ADDR_W-1:0]           addr_q;
  logic [2:0]                  cmd_q;
  logic [DATA_W-1:0]           wdata_q;
  logic [MASK_W-1:0]           wmask_q;
  logic [1:0]                  rsp_valid_q;
  logic [DATA_W-1:0]           rsp_data_q;
  logic                        orphan_q;

  logic [1:0]                  elig;
  port_id_t                    gnt_port;
  logic                        grant;
  logic                        cmd_done, wdf_done;
  logic                        tag_push, tag_pop, rsp_fire;
  logic                        tag_full, tag_empty;
  port_id_t                    tag_head;
  logic [$clog2(TAG_DEPTH):0]  tag_count;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid_i[i] & init_calib_complete_i & (req_write_i[i] | ~tag_full);
    end
    gnt_port    = elig[rr_q] ? rr_q : ~rr_q;
    grant       = (state_q == IDLE) & (|elig);
    req_ready_o = grant ? port_onehot(gnt_port) : 2'b00;
  end

  assign cmd_done = app_en_q & app_rdy_i;
  assign wdf_done = wren_q & app_wdf_rdy_i;
  assign tag_push = cmd_done & (cmd_q == MIG_CMD_READ);
  assign tag_pop  = app_rd_data_valid_i;
  assign rsp_fire = tag_pop & ~tag_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      gnt_q    <= '0;
      app_en_q <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      cmd_q    <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            state_q  <= ISSUE;
            gnt_q    <= gnt_port;
            rr_q     <= ~gnt_port;
            addr_q   <= req_addr_i[gnt_port];
            cmd_q    <= req_write_i[gnt_port] ? MIG_CMD_WRITE : MIG_CMD_READ;
            wdata_q  <= req_wdata_i[gnt_port];
            wmask_q  <= req_wmask_i[gnt_port];
            app_en_q <= 1'b1;
            wren_q   <= req_write_i[gnt_port];
          end
        end
        ISSUE: begin
          // Command and write-data handshakes retire independently.
          if (cmd_done) app_en_q <= 1'b0;
          if (wdf_done) wren_q   <= 1'b0;
          if ((cmd_done | ~app_en_q) & (wdf_done | ~wren_q)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      orphan_q    <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_fire ? port_onehot(tag_head) : 2'b00;
      if (rsp_fire)              rsp_data_q <= app_rd_data_i;
      if (tag_pop && tag_empty)  orphan_q   <= 1'b1;
    end
  end

  mig7_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (tag_push),
    .push_data_i (gnt_q),
    .pop_i       (tag_pop),
    .head_o      (tag_head),
    .full_o      (tag_full),
    .empty_o     (tag_empty),
    .count_o     (tag_count)
  );

  assign app_addr_o     = addr_q;
  assign app_cmd_o      = cmd_q;
  assign app_en_o       = app_en_q;
  assign app_wdf_data_o = wdata_q;
  assign app_wdf_mask_o = wmask_q;
  assign app_wdf_wren_o = wren_q;
  assign app_wdf_end_o  = wren_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign rd_orphan_o    = orphan_q;
  assign app_sr_req_o   = 1'b0;
  assign app_ref_req_o  = 1'b0;
  assign app_zq_req_o   = 1'b0;

`ifdef MIG7_ARB_STATS_EN
  logic [1:0][31:0]            grants_q;
  logic [$clog2(TAG_DEPTH):0]  max_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grants_q  <= '0;
      max_out_q <= '0;
    end else begin
      if (grant) grants_q[gnt_port] <= grants_q[gnt_port] + 32'd1;
      if (tag_count > max_out_q) max_out_q <= tag_count;
    end
  end

  assign stat_grants_o          = grants_q;
  assign stat_max_outstanding_o = max_out_q;
`else
  logic unused_tag_count;
  assign unused_tag_count = ^tag_count;
`endif

endmodule
